// File: rtl/prefix_pkg.sv
// Shared types for the prefix-sum decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, output record struct at the default widths.
package prefix_pkg;

  localparam int N_DEF     = 32;
  localparam int CNT_W_DEF = 16;

  // FIRST: next accepted word starts a stream (prev taken as 0, index 0).
  // RUN:   next accepted word is decoded against the previous accepted word.
  typedef enum logic {
    FIRST = 1'b0,
    RUN   = 1'b1
  } state_t;

  // One decoded element as presented on OUT_*.
  typedef struct packed {
    logic [N_DEF-1:0]     data;
    logic                 borrow;
    logic [CNT_W_DEF-1:0] index;
    logic                 last;
  } out_rec_t;

endpackage

// File: rtl/prefix_diff_sub.sv
// N-bit unsigned subtractor returning {borrow, a - b}.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (operands), borrow (a < b), diff (a - b mod 2^N).
module prefix_diff_sub #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         borrow,
  output logic [N-1:0] diff
);

  // The extra top bit of an (N+1)-bit subtraction is exactly a < b.
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/prefix_diff.sv
// Inverts a prefix-sum stream: out[i] = in[i] - in[i-1] mod 2^N, in[-1] = 0.
// Latency: one cycle from input transfer to OUT_valid.
// Backpressure: single output register; IN_ready = !OUT_valid || OUT_ready.
// Ports: clk/rst, IN_valid/IN_data/IN_last/IN_ready upstream,
//        OUT_valid/OUT_data/OUT_borrow/OUT_index/OUT_last/OUT_ready downstream.
module prefix_diff
  import prefix_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IN_valid,
  input  logic [N-1:0]     IN_data,
  input  logic             IN_last,
  output logic             IN_ready,
  output logic             OUT_valid,
  output logic [N-1:0]     OUT_data,
  output logic             OUT_borrow,
  output logic [CNT_W-1:0] OUT_index,
  output logic             OUT_last,
  input  logic             OUT_ready
);

  // Same field layout as out_rec_t, sized by this instance's parameters.
  typedef struct packed {
    logic [N-1:0]     data;
    logic             borrow;
    logic [CNT_W-1:0] index;
    logic             last;
  } rec_t;

  state_t           state;
  logic [N-1:0]     prev;
  logic [CNT_W-1:0] cnt;
  rec_t             out_q;
  logic             out_vld_q;

  logic             in_xfer;
  logic [N-1:0]     prev_eff;
  logic [CNT_W-1:0] idx_cur;
  logic             sub_borrow;
  logic [N-1:0]     sub_diff;

  // Output register is free, or being emptied this very cycle.
  assign IN_ready = !out_vld_q || OUT_ready;
  assign in_xfer  = IN_valid && IN_ready;

  // In FIRST the subtrahend is zero, which also forces borrow to 0.
  assign prev_eff = (state == RUN) ? prev : '0;
  assign idx_cur  = (state == RUN) ? cnt  : '0;

  prefix_diff_sub #(.N(N)) u_sub (
    .a      (IN_data),
    .b      (prev_eff),
    .borrow (sub_borrow),
    .diff   (sub_diff)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FIRST;
      prev      <= '0;
      cnt       <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (in_xfer) begin
      // Load (or replace on a simultaneous output transfer) with no bubble.
      out_q.data   <= sub_diff;
      out_q.borrow <= sub_borrow;
      out_q.index  <= idx_cur;
      out_q.last   <= IN_last;
      out_vld_q    <= 1'b1;
      prev         <= IN_data;
      if (IN_last) begin
        state <= FIRST;
        cnt   <= '0;
      end else begin
        state <= RUN;
        // Wraps silently at 2^CNT_W; stream state is unaffected.
        cnt   <= idx_cur + CNT_W'(1);
      end
    end else if (OUT_ready) begin
      out_vld_q <= 1'b0;
    end
  end

  assign OUT_valid  = out_vld_q;
  assign OUT_data   = out_q.data;
  assign OUT_borrow = out_q.borrow;
  assign OUT_index  = out_q.index;
  assign OUT_last   = out_q.last;

endmodule

// File: tb/tb_prefix_diff.sv
// Testbench for prefix_diff: directed vectors plus a random valid/ready run.
// Latency: n/a.
// Backpressure: driven by the bench through OUT_ready.
module tb_prefix_diff;

  logic        clk = 1'b0;
  logic        rst;
  logic        IN_valid;
  logic [31:0] IN_data;
  logic        IN_last;
  logic        IN_ready;
  logic        OUT_valid;
  logic [31:0] OUT_data;
  logic        OUT_borrow;
  logic [15:0] OUT_index;
  logic        OUT_last;
  logic        OUT_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        borrow;
    logic [15:0] idx;
    logic        last;
  } exp_t;

  exp_t sb[$];

  prefix_diff #(.N(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .IN_valid   (IN_valid),
    .IN_data    (IN_data),
    .IN_last    (IN_last),
    .IN_ready   (IN_ready),
    .OUT_valid  (OUT_valid),
    .OUT_data   (OUT_data),
    .OUT_borrow (OUT_borrow),
    .OUT_index  (OUT_index),
    .OUT_last   (OUT_last),
    .OUT_ready  (OUT_ready)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] d, input logic b,
                              input logic [15:0] i, input logic l);
    exp_t e;
    e.data = d; e.borrow = b; e.idx = i; e.last = l;
    return e;
  endfunction

  task automatic check(input string name, input logic ok,
                       input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Scoreboard monitor: an output transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && OUT_valid && OUT_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got data=%0h idx=%0d", OUT_data, OUT_index);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (OUT_data !== e.data || OUT_borrow !== e.borrow ||
            OUT_index !== e.idx || OUT_last !== e.last) begin
          failures++;
          $display("FAIL sb_out got data=%0h b=%0d idx=%0d last=%0d want data=%0h b=%0d idx=%0d last=%0d",
                   OUT_data, OUT_borrow, OUT_index, OUT_last,
                   e.data, e.borrow, e.idx, e.last);
        end
      end
    end
  end

  // Presents one word, waits (bounded) for acceptance, pushes its expectation.
  task automatic send(input logic [31:0] d, input logic l, input exp_t e,
                      output int waited);
    waited   = 0;
    IN_valid = 1'b1;
    IN_data  = d;
    IN_last  = l;
    forever begin
      @(negedge clk);
      if (IN_ready) break;
      waited++;
      if (waited > 50) begin
        check("send_timeout", 1'b0, 32'(waited), 32'd50);
        break;
      end
    end
    if (IN_ready) sb.push_back(e);
    @(posedge clk);
    #1;
    IN_valid = 1'b0;
  endtask

  int w;
  int stall_total;

  initial begin
    rst       = 1'b1;
    IN_valid  = 1'b0;
    IN_data   = '0;
    IN_last   = 1'b0;
    OUT_ready = 1'b1;

    // Reset state.
    #1;
    check("rst_out_valid", OUT_valid == 1'b0, 32'(OUT_valid), 32'd0);
    check("rst_out_fields", OUT_data == 0 && OUT_borrow == 0 && OUT_index == 0 && OUT_last == 0,
          OUT_data, 32'd0);
    check("rst_in_ready", IN_ready == 1'b1, 32'(IN_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic stream.
    send(32'd5,  1'b0, mk(32'd5,  1'b0, 16'd0, 1'b0), w);
    send(32'd12, 1'b0, mk(32'd7,  1'b0, 16'd1, 1'b0), w);
    send(32'd12, 1'b0, mk(32'd0,  1'b0, 16'd2, 1'b0), w);
    send(32'd30, 1'b1, mk(32'd18, 1'b0, 16'd3, 1'b1), w);

    // Wrapping subtraction with borrow.
    send(32'hFFFF_FFF0, 1'b0, mk(32'hFFFF_FFF0, 1'b0, 16'd0, 1'b0), w);
    send(32'h0000_0010, 1'b1, mk(32'h0000_0020, 1'b1, 16'd1, 1'b1), w);

    // Back-to-back streams including a single-element stream.
    send(32'd3, 1'b1, mk(32'd3, 1'b0, 16'd0, 1'b1), w);
    send(32'd4, 1'b0, mk(32'd4, 1'b0, 16'd0, 1'b0), w);
    send(32'd9, 1'b1, mk(32'd5, 1'b0, 16'd1, 1'b1), w);

    // Full throughput: triangular numbers decode to 1..8 with no stalls.
    stall_total = 0;
    for (int k = 1; k <= 8; k++) begin
      send(32'(k * (k + 1) / 2), k == 8, mk(32'(k), 1'b0, 16'(k - 1), k == 8), w);
      stall_total += w;
    end
    check("throughput_stalls", stall_total == 0, 32'(stall_total), 32'd0);

    // Backpressure: output must hold while the next word waits.
    send(32'd10, 1'b0, mk(32'd10, 1'b0, 16'd0, 1'b0), w);
    OUT_ready = 1'b0;
    IN_valid  = 1'b1;
    IN_data   = 32'd15;
    IN_last   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", IN_ready == 1'b0, 32'(IN_ready), 32'd0);
      check("stall_hold", OUT_valid && OUT_data == 32'd10 && OUT_index == 16'd0 && !OUT_last,
            OUT_data, 32'd10);
      @(posedge clk);
      #1;
    end
    OUT_ready = 1'b1;
    send(32'd15, 1'b0, mk(32'd5, 1'b0, 16'd1, 1'b0), w);
    check("release_no_wait", w == 0, 32'(w), 32'd0);
    send(32'd21, 1'b1, mk(32'd6, 1'b0, 16'd2, 1'b1), w);

    // Reset mid-stream discards the held element and partial stream.
    send(32'd1, 1'b0, mk(32'd1, 1'b0, 16'd0, 1'b0), w);
    send(32'd2, 1'b0, mk(32'd1, 1'b0, 16'd1, 1'b0), w);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", OUT_valid == 1'b0, 32'(OUT_valid), 32'd0);
    check("midrst_in_ready", IN_ready == 1'b1, 32'(IN_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(32'd8, 1'b1, mk(32'd8, 1'b0, 16'd0, 1'b1), w);

    // Random valid/ready against a reference model.
    begin
      int          acc = 0;
      int          cyc = 0;
      logic [31:0] mprev = '0;
      logic        mfirst = 1'b1;
      logic [15:0] midx = '0;
      logic [31:0] base;
      exp_t        e;
      while (acc < 1000 && cyc < 20000) begin
        IN_valid  = ($urandom_range(0, 3) != 0);
        IN_data   = ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
        IN_last   = ($urandom_range(0, 7) == 0);
        OUT_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (IN_valid && IN_ready) begin
          base     = mfirst ? 32'd0 : mprev;
          e.data   = IN_data - base;
          e.borrow = (IN_data < base);
          e.idx    = mfirst ? 16'd0 : midx;
          e.last   = IN_last;
          sb.push_back(e);
          mprev = IN_data;
          if (IN_last) begin
            mfirst = 1'b1;
            midx   = '0;
          end else begin
            mfirst = 1'b0;
            midx   = e.idx + 16'd1;
          end
          acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      check("random_accepted", acc == 1000, 32'(acc), 32'd1000);
    end

    // Drain.
    IN_valid  = 1'b0;
    OUT_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", sb.size() == 0, 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prefix_diff.md
PREFIX_DIFF -- requirements
Module: prefix_diff

Interface
REQ-001 Parameter N, default 32: data word width in bits.
REQ-002 Parameter CNT_W, default 16: element-index counter width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 IN_valid  input  1  upstream holds a valid prefix-sum word.
REQ-006 IN_data  input  N  prefix-sum word, unsigned.
REQ-007 IN_last  input  1  current word is the final element of its stream.
REQ-008 IN_ready  output  1  block accepts the word this cycle.
REQ-009 OUT_valid  output  1  OUT_* fields hold a valid decoded element.
REQ-010 OUT_data  output  N  decoded element: difference of consecutive prefix sums.
REQ-011 OUT_borrow  output  1  decoded subtraction wrapped (IN_data < previous sum).
REQ-012 OUT_index  output  CNT_W  zero-based position of the element within its stream.
REQ-013 OUT_last  output  1  element is the last of its stream.
REQ-014 OUT_ready  input  1  downstream accepts the output this cycle.

Function
REQ-015 The block shall invert a prefix-sum stream: out[i] = in[i] - in[i-1] mod 2^N, with in[-1] = 0.
REQ-016 Input transfer shall occur when IN_valid && IN_ready; output transfer shall occur when OUT_valid && OUT_ready.
REQ-017 IN_ready shall equal !OUT_valid || OUT_ready, combinationally, with no dependence on IN_valid.
REQ-018 Latency shall be one cycle: an accepted word appears on OUT_* at the following rising edge.
REQ-019 OUT_* shall hold stable while OUT_valid && !OUT_ready.
REQ-020 OUT_valid shall clear after an output transfer with no simultaneous input transfer.
REQ-021 A simultaneous input and output transfer shall replace the output register with no bubble, sustaining one element per cycle.
REQ-022 FSM states: FIRST (prev treated as 0, index 0) and RUN (prev = last accepted word).
REQ-023 FIRST -> RUN on an accepted word with IN_last=0.
REQ-024 RUN -> FIRST on an accepted word with IN_last=1.
REQ-025 FIRST -> FIRST on an accepted word with IN_last=1, which is a single-element stream.
REQ-026 Index rules: index shall increment on each accepted word in RUN and wrap from 2^CNT_W-1 to 0 silently; stream state shall not change on wrap.
REQ-027 OUT_borrow shall equal the unsigned comparison IN_data < prev and shall always be 0 in state FIRST.
REQ-028 The subtraction shall be N bits wide with the carry discarded except as OUT_borrow.
REQ-029 Inputs shall be ignored, and state and prev shall not update, while IN_ready=0.

Reset
REQ-030 On rst: OUT_valid=0, OUT_data=0, OUT_borrow=0, OUT_index=0, OUT_last=0, prev=0, state=FIRST.
REQ-031 Reset asserted mid-stream shall discard the held output and any partial stream; the first word after release decodes as a stream start.
REQ-032 IN_ready shall be 1 while in reset, since it follows from OUT_valid=0; upstream shall not transfer words during rst.

Structure
REQ-033 Package prefix_pkg shall hold the FSM state enum and the output record struct {data, borrow, index, last}, parameterised via N/CNT_W defaults.
REQ-034 One sub-module, prefix_diff_sub, shall be instantiated as a combinational N-bit subtractor returning {borrow, difference}.

Verification
REQ-035 Stream 5, 12, 12, 30 (last on 30), OUT_ready=1 -> outputs 5, 7, 0, 18; index 0..3; OUT_last only on 18; borrow all 0.
REQ-036 N=32, stream 0xFFFFFFF0, 0x00000010 -> outputs 0xFFFFFFF0 (borrow 0), then 0x00000020 (borrow 1).
REQ-037 Back-to-back streams [3 last], [4, 9 last] -> outputs 3 (idx 0, last), 4 (idx 0), 5 (idx 1, last).
REQ-038 Hold OUT_ready=0 for 3 cycles with IN_valid=1 -> IN_ready=0, OUT_* stable; release -> no data loss or duplication, one element per cycle.
REQ-039 Assert rst after 2 of 4 words are accepted -> OUT_valid drops immediately; next word 8 -> output 8, index 0.
REQ-040 Random valid/ready stream of 1000 words checked against reference model -> zero mismatches, full throughput when both held high.
